// File: rtl/reg_pipeline_elastico.sv
// Elastic multi-stage pipeline register with valid/ready handshake,
// bubble collapsing, global stall (parada) and synchronous flush (limpar).
// Occupancy is tracked in a registered counter that mirrors the valid bits.
module reg_pipeline_elastico #(
  parameter int TAM         = 32,
  parameter int ESTAGIOS    = 2,
  parameter int LIMPA_DADOS = 1
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              parada,
  input  logic                              limpar,
  input  logic                              in_valido,
  input  logic [TAM-1:0]                    in_dado,
  output logic                              in_pronto,
  output logic                              out_valido,
  output logic [TAM-1:0]                    out_dado,
  input  logic                              out_pronto,
  output logic [$clog2(ESTAGIOS+1)-1:0]     ocupacao
);

  localparam int OW = $clog2(ESTAGIOS+1);

  logic [ESTAGIOS-1:0] v;
  logic [ESTAGIOS-1:0] en;
  logic [ESTAGIOS-1:0] src_v;
  logic [TAM-1:0]      d     [ESTAGIOS];
  logic [TAM-1:0]      src_d [ESTAGIOS];
  logic                acc;
  logic                go;
  logic                in_xfer;
  logic                out_xfer;

  assign go = ~parada & ~limpar;

  // Advance enables ripple from the output side: a stage moves if the next one moves or it is empty.
  always_comb begin
    acc = out_pronto;
    en  = '0;
    for (int i = ESTAGIOS - 1; i >= 0; i--) begin
      acc   = acc | ~v[i];
      en[i] = acc & go;
    end
  end

  // Each stage's load source is the previous stage; stage 0 takes the upstream beat.
  always_comb begin
    src_v    = '0;
    src_v[0] = in_valido;
    src_d[0] = in_dado;
    for (int i = 1; i < ESTAGIOS; i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
  end

  // Stage registers: flush clears valid bits (and data when configured), otherwise enabled stages load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v <= '0;
      for (int i = 0; i < ESTAGIOS; i++) d[i] <= '0;
    end else if (limpar) begin
      v <= '0;
      if (LIMPA_DADOS != 0) begin
        for (int i = 0; i < ESTAGIOS; i++) d[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ESTAGIOS; i++) begin
        if (en[i]) begin
          v[i] <= src_v[i];
          d[i] <= src_d[i];
        end
      end
    end
  end

  assign in_pronto  = en[0];
  assign out_valido = v[ESTAGIOS-1] & go;
  assign out_dado   = d[ESTAGIOS-1];
  assign in_xfer    = in_valido & in_pronto;
  assign out_xfer   = out_valido & out_pronto;

  // Occupancy counter: up on input-only transfer, down on output-only transfer, zeroed by flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ocupacao <= '0;
    end else if (limpar) begin
      ocupacao <= '0;
    end else if (in_xfer && !out_xfer) begin
      ocupacao <= ocupacao + OW'(1);
    end else if (out_xfer && !in_xfer) begin
      ocupacao <= ocupacao - OW'(1);
    end
  end

endmodule

// File: tb/tb_reg_pipeline_elastico.sv
// Scoreboard bench for reg_pipeline_elastico: a 3-stage and a 1-stage instance.
// Accepted beats are queued; monitors pop and compare whenever an output transfer happens.
module tb_reg_pipeline_elastico;

  logic        clock = 1'b0;
  logic        reset_n;

  logic        parada3, limpar3, in_valido3, in_pronto3, out_valido3, out_pronto3;
  logic [31:0] in_dado3, out_dado3;
  logic [1:0]  ocupacao3;

  logic        parada1, limpar1, in_valido1, in_pronto1, out_valido1, out_pronto1;
  logic [31:0] in_dado1, out_dado1;
  logic [0:0]  ocupacao1;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] q3[$];
  logic [31:0] q1[$];
  bit          lat_req = 1'b0;
  bit          lat_arm = 1'b0;
  bit          lat1_arm = 1'b0;
  int          lat_start = 0;
  int          lat1_start = 0;
  int          tries;

  reg_pipeline_elastico #(.TAM(32), .ESTAGIOS(3), .LIMPA_DADOS(1)) dut3 (
    .clock(clock), .reset_n(reset_n), .parada(parada3), .limpar(limpar3),
    .in_valido(in_valido3), .in_dado(in_dado3), .in_pronto(in_pronto3),
    .out_valido(out_valido3), .out_dado(out_dado3), .out_pronto(out_pronto3),
    .ocupacao(ocupacao3)
  );

  reg_pipeline_elastico #(.TAM(32), .ESTAGIOS(1), .LIMPA_DADOS(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .parada(parada1), .limpar(limpar1),
    .in_valido(in_valido1), .in_dado(in_dado1), .in_pronto(in_pronto1),
    .out_valido(out_valido1), .out_dado(out_dado1), .out_pronto(out_pronto1),
    .ocupacao(ocupacao1)
  );

  // Free-running clock; inputs change on the falling edge, sampling happens 1 time unit before the rising edge.
  always #5 clock = ~clock;

  // Counts rising edges so the monitors can measure latency.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Offers one beat to the 3-stage pipe until it is taken; queues it as expected output on acceptance.
  task automatic applyStimulus(input logic [31:0] x, output int n);
    bit ok;
    ok = 1'b0;
    n  = 0;
    in_valido3 = 1'b1;
    in_dado3   = x;
    while (!ok && n < 20) begin
      #4;
      n++;
      if (in_pronto3) begin
        ok = 1'b1;
        q3.push_back(x);
        if (lat_req) begin
          lat_arm   = 1'b1;
          lat_start = cyc + 1;
          lat_req   = 1'b0;
        end
      end
      @(negedge clock);
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: beat 0x%0h not accepted within %0d cycles", x, n);
    end
  endtask

  task automatic idle(input int n);
    in_valido3 = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  // Monitor for the 3-stage pipe: every output transfer must match the oldest queued beat.
  initial begin : mon3
    logic [31:0] e;
    forever begin
      @(negedge clock);
      #4;
      if (out_valido3 && out_pronto3) begin
        if (q3.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL out3_unexpected: got 0x%0h expected no beat", out_dado3);
        end else begin
          e = q3.pop_front();
          checkOutput("out3_dado", out_dado3, e);
          if (lat_arm) begin
            checkOutput("latency3", 32'(cyc - lat_start), 32'd2);
            lat_arm = 1'b0;
          end
        end
      end
    end
  end

  // Monitor for the 1-stage pipe.
  initial begin : mon1
    logic [31:0] e;
    forever begin
      @(negedge clock);
      #4;
      if (out_valido1 && out_pronto1) begin
        if (q1.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL out1_unexpected: got 0x%0h expected no beat", out_dado1);
        end else begin
          e = q1.pop_front();
          checkOutput("out1_dado", out_dado1, e);
          if (lat1_arm) begin
            checkOutput("latency1", 32'(cyc - lat1_start), 32'd0);
            lat1_arm = 1'b0;
          end
        end
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run still active at time %0t, expected to have finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    parada3 = 1'b0; limpar3 = 1'b0; in_valido3 = 1'b0; in_dado3 = '0; out_pronto3 = 1'b0;
    parada1 = 1'b0; limpar1 = 1'b0; in_valido1 = 1'b0; in_dado1 = '0; out_pronto1 = 1'b0;

    repeat (2) @(negedge clock);
    #1;
    checkOutput("rst_out_valido", 32'(out_valido3), 32'd0);
    checkOutput("rst_out_dado", out_dado3, 32'd0);
    checkOutput("rst_ocupacao", 32'(ocupacao3), 32'd0);
    checkOutput("rst_in_pronto", 32'(in_pronto3), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Stream 0x1..0x8 with the output always ready.
    out_pronto3 = 1'b1;
    lat_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(32'(k), tries);
      checkOutput("stream_first_try", 32'(tries), 32'd1);
      if (k == 6) checkOutput("stream_ocupacao", 32'(ocupacao3), 32'd3);
    end
    idle(6);
    checkOutput("stream_drained", 32'(q3.size()), 32'd0);
    checkOutput("stream_ocup_end", 32'(ocupacao3), 32'd0);

    // Back-pressure fill: three beats fit, the fourth is refused until the output is released.
    out_pronto3 = 1'b0;
    applyStimulus(32'hA, tries);
    applyStimulus(32'hB, tries);
    applyStimulus(32'hC, tries);
    in_valido3 = 1'b1;
    in_dado3   = 32'hD;
    #4;
    checkOutput("full_in_pronto", 32'(in_pronto3), 32'd0);
    checkOutput("full_ocupacao", 32'(ocupacao3), 32'd3);
    checkOutput("full_out_valido", 32'(out_valido3), 32'd1);
    @(negedge clock);
    out_pronto3 = 1'b1;
    applyStimulus(32'hD, tries);
    checkOutput("full_accept_emit", 32'(tries), 32'd1);
    idle(6);
    checkOutput("bp_drained", 32'(q3.size()), 32'd0);

    // Bubble collapse: an empty stage accepts even with the output blocked.
    out_pronto3 = 1'b0;
    applyStimulus(32'h5, tries);
    idle(1);
    applyStimulus(32'h6, tries);
    checkOutput("bubble_first_try", 32'(tries), 32'd1);
    checkOutput("bubble_ocupacao", 32'(ocupacao3), 32'd2);
    in_valido3  = 1'b0;
    out_pronto3 = 1'b1;
    idle(5);
    checkOutput("bubble_drained", 32'(q3.size()), 32'd0);

    // Stall: full pipe frozen for four cycles while both sides are willing.
    out_pronto3 = 1'b0;
    applyStimulus(32'h11, tries);
    applyStimulus(32'h22, tries);
    applyStimulus(32'h33, tries);
    in_valido3  = 1'b1;
    in_dado3    = 32'h44;
    parada3     = 1'b1;
    out_pronto3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #4;
      checkOutput("stall_out_valido", 32'(out_valido3), 32'd0);
      checkOutput("stall_in_pronto", 32'(in_pronto3), 32'd0);
      checkOutput("stall_ocupacao", 32'(ocupacao3), 32'd3);
      @(negedge clock);
    end
    parada3 = 1'b0;
    idle(6);
    checkOutput("stall_drained", 32'(q3.size()), 32'd0);

    // Flush with a beat offered in the same cycle.
    out_pronto3 = 1'b0;
    applyStimulus(32'h55, tries);
    applyStimulus(32'h66, tries);
    idle(2);
    checkOutput("pre_flush_ocupacao", 32'(ocupacao3), 32'd2);
    checkOutput("pre_flush_dado", out_dado3, 32'h55);
    limpar3    = 1'b1;
    in_valido3 = 1'b1;
    in_dado3   = 32'h77;
    #4;
    checkOutput("flush_in_pronto", 32'(in_pronto3), 32'd0);
    checkOutput("flush_out_valido", 32'(out_valido3), 32'd0);
    @(negedge clock);
    limpar3    = 1'b0;
    in_valido3 = 1'b0;
    q3.delete();
    checkOutput("post_flush_ocupacao", 32'(ocupacao3), 32'd0);
    checkOutput("post_flush_out_valido", 32'(out_valido3), 32'd0);
    checkOutput("post_flush_dado", out_dado3, 32'd0);
    out_pronto3 = 1'b1;
    idle(4);

    // Asynchronous reset between edges while beats are in flight.
    applyStimulus(32'h101, tries);
    applyStimulus(32'h102, tries);
    applyStimulus(32'h103, tries);
    in_valido3 = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_out_valido", 32'(out_valido3), 32'd0);
    checkOutput("arst_ocupacao", 32'(ocupacao3), 32'd0);
    checkOutput("arst_dado", out_dado3, 32'd0);
    q3.delete();
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    lat_req = 1'b1;
    applyStimulus(32'h201, tries);
    applyStimulus(32'h202, tries);
    idle(6);
    checkOutput("arst_drained", 32'(q3.size()), 32'd0);

    // Single-stage variant: same stream, visible right after the accepting edge.
    out_pronto1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valido1 = 1'b1;
      in_dado1   = 32'hC0 + 32'(k);
      #4;
      checkOutput("s1_in_pronto", 32'(in_pronto1), 32'd1);
      if (in_pronto1) begin
        q1.push_back(in_dado1);
        if (k == 1) begin
          lat1_arm   = 1'b1;
          lat1_start = cyc + 1;
        end
      end
      @(negedge clock);
      if (k == 4) checkOutput("s1_ocupacao", 32'(ocupacao1), 32'd1);
    end
    in_valido1 = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("s1_drained", 32'(q1.size()), 32'd0);
    checkOutput("s1_ocup_end", 32'(ocupacao1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
